// File: rtl/div_slew_sequencer.sv
//==============================================================================
// Module      : div_slew_sequencer
// Description : Moves a clock divisor toward a requested target, changing it
//               only at slow-clock period boundaries. Optional slew limiting
//               via macro DIV_SLEW_SEQUENCER_SLEW_EN (MAX_STEP per update).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_slew_sequencer #(
    parameter int DIV_W    = 4,
    parameter int MIN_DIV  = 2,
    parameter int MAX_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req_valid,
    input  logic [DIV_W-1:0] i_req_div,
    input  logic             i_period_end,
    output logic [DIV_W-1:0] o_cur_div,
    output logic             o_upd_valid,
    output logic             o_busy,
    output logic [15:0]      o_upd_count
);

`ifdef DIV_SLEW_SEQUENCER_SLEW_EN
    localparam bit c_slew_en = 1'b1;
`else
    localparam bit c_slew_en = 1'b0;
`endif

    // Without slew limiting the limit is the largest possible distance, so
    // every update lands directly on the target.
    localparam logic [DIV_W:0]   c_step_lim = c_slew_en ? (DIV_W+1)'(MAX_STEP)
                                                        : {1'b0, {DIV_W{1'b1}}};
    localparam logic [DIV_W-1:0] c_min_div  = DIV_W'(MIN_DIV);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_tgt;
    logic [DIV_W-1:0] r_cur;
    logic             r_upd;
    logic             r_busy;
    logic [15:0]      r_upd_count;

    logic [DIV_W-1:0] w_tgt_nxt;
    logic [DIV_W-1:0] w_cur_nxt;
    logic             w_upd;
    logic             w_up;
    logic [DIV_W:0]   w_diff;
    logic [DIV_W:0]   w_step;
    logic [DIV_W:0]   w_cur_ext;

    // Extended-width step; the carry bit flags a wrap, which can never be taken.
    always_comb begin
        w_up      = (r_tgt > r_cur);
        w_diff    = w_up ? ({1'b0, r_tgt} - {1'b0, r_cur})
                         : ({1'b0, r_cur} - {1'b0, r_tgt});
        w_step    = (w_diff > c_step_lim) ? c_step_lim : w_diff;
        w_cur_ext = w_up ? ({1'b0, r_cur} + w_step)
                         : ({1'b0, r_cur} - w_step);
    end

    always_comb begin
        w_tgt_nxt = r_tgt;
        if (i_req_valid) begin
            w_tgt_nxt = (i_req_div < c_min_div) ? {DIV_W{1'b1}} : i_req_div;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_upd       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_tgt != r_cur) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_tgt == r_cur) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_period_end && !w_cur_ext[DIV_W]) begin
                    w_cur_nxt = w_cur_ext[DIV_W-1:0];
                    w_upd     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tgt       <= {DIV_W{1'b1}};
            r_cur       <= {DIV_W{1'b1}};
            r_upd       <= 1'b0;
            r_busy      <= 1'b0;
            r_upd_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cur   <= w_cur_nxt;
            r_upd   <= w_upd;
            r_busy  <= (w_state_nxt == ST_WAIT);
            if (w_upd && (r_upd_count != 16'hFFFF)) begin
                r_upd_count <= r_upd_count + 16'h0001;
            end
        end
    end

    assign o_cur_div   = r_cur;
    assign o_upd_valid = r_upd;
    assign o_busy      = r_busy;
    assign o_upd_count = r_upd_count;

endmodule

`default_nettype wire

// File: tb/tb_div_slew_sequencer.sv
//==============================================================================
// Module      : tb_div_slew_sequencer
// Description : Directed vector bench for div_slew_sequencer (either build).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_slew_sequencer;

    logic        clk;
    logic        reset;
    logic        i_req_valid;
    logic [3:0]  i_req_div;
    logic        i_period_end;
    logic [3:0]  o_cur_div;
    logic        o_upd_valid;
    logic        o_busy;
    logic [15:0] o_upd_count;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        rv;
        logic [3:0]  d;
        logic        pe;
        logic [3:0]  cur;
        logic        upd;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    div_slew_sequencer #(
        .DIV_W   (4),
        .MIN_DIV (2),
        .MAX_STEP(1)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .i_req_div   (i_req_div),
        .i_period_end(i_period_end),
        .o_cur_div   (o_cur_div),
        .o_upd_valid (o_upd_valid),
        .o_busy      (o_busy),
        .o_upd_count (o_upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [3:0] d, input logic pe);
        @(negedge clk);
        reset        = rst;
        i_req_valid  = rv;
        i_req_div    = d;
        i_period_end = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rv, input logic [3:0] d, input logic pe,
                       input logic [3:0] cur, input logic upd, input logic busy,
                       input logic [15:0] cnt);
        vec_t v;
        v.rv = rv; v.d = d; v.pe = pe;
        v.cur = cur; v.upd = upd; v.busy = busy; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        int          n_pre;
        logic [3:0]  pre_cur;
        logic [15:0] pre_cnt;
        int          guard;

        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        i_req_valid  = 1'b1;
        i_req_div    = 4'h5;
        i_period_end = 1'b1;

        // rv, d, pe | cur, upd, busy, cnt  (each row = one clock edge)
        add(0, 4'h0, 1, 4'hF, 0, 0, 16'd0);
        add(0, 4'h0, 0, 4'hF, 0, 0, 16'd0);
        add(0, 4'h0, 1, 4'hF, 0, 0, 16'd0);
        add(0, 4'h0, 1, 4'hF, 0, 0, 16'd0);
`ifdef DIV_SLEW_SEQUENCER_SLEW_EN
        add(1, 4'hC, 0, 4'hF, 0, 0, 16'd0);
        add(0, 4'h0, 0, 4'hF, 0, 1, 16'd0);
        add(0, 4'h0, 1, 4'hE, 1, 1, 16'd1);
        add(0, 4'h0, 1, 4'hD, 1, 1, 16'd2);
        add(0, 4'h0, 1, 4'hC, 1, 1, 16'd3);
        add(0, 4'h0, 0, 4'hC, 0, 0, 16'd3);
        add(1, 4'h1, 0, 4'hC, 0, 0, 16'd3);
        add(0, 4'h0, 0, 4'hC, 0, 1, 16'd3);
        add(0, 4'h0, 1, 4'hD, 1, 1, 16'd4);
        add(0, 4'h0, 1, 4'hE, 1, 1, 16'd5);
        add(0, 4'h0, 1, 4'hF, 1, 1, 16'd6);
        add(0, 4'h0, 1, 4'hF, 0, 0, 16'd6);
        add(1, 4'h8, 0, 4'hF, 0, 0, 16'd6);
        add(0, 4'h0, 0, 4'hF, 0, 1, 16'd6);
        add(0, 4'h0, 1, 4'hE, 1, 1, 16'd7);
        add(0, 4'h0, 1, 4'hD, 1, 1, 16'd8);
        add(1, 4'hD, 1, 4'hC, 1, 1, 16'd9);
        add(0, 4'h0, 0, 4'hC, 0, 1, 16'd9);
        add(0, 4'h0, 1, 4'hD, 1, 1, 16'd10);
        add(0, 4'h0, 1, 4'hD, 0, 0, 16'd10);
        add(1, 4'h8, 0, 4'hD, 0, 0, 16'd10);
        add(1, 4'hD, 0, 4'hD, 0, 1, 16'd10);
        add(0, 4'h0, 1, 4'hD, 0, 0, 16'd10);
        n_pre   = 3;
        pre_cur = 4'hA;
        pre_cnt = 16'd13;
`else
        add(1, 4'h3, 0, 4'hF, 0, 0, 16'd0);
        add(0, 4'h0, 0, 4'hF, 0, 1, 16'd0);
        add(0, 4'h0, 1, 4'h3, 1, 1, 16'd1);
        add(0, 4'h0, 1, 4'h3, 0, 0, 16'd1);
        add(1, 4'h1, 0, 4'h3, 0, 0, 16'd1);
        add(0, 4'h0, 0, 4'h3, 0, 1, 16'd1);
        add(0, 4'h0, 1, 4'hF, 1, 1, 16'd2);
        add(0, 4'h0, 0, 4'hF, 0, 0, 16'd2);
        add(1, 4'h8, 0, 4'hF, 0, 0, 16'd2);
        add(1, 4'hF, 0, 4'hF, 0, 1, 16'd2);
        add(0, 4'h0, 1, 4'hF, 0, 0, 16'd2);
        add(1, 4'h5, 0, 4'hF, 0, 0, 16'd2);
        add(0, 4'h0, 0, 4'hF, 0, 1, 16'd2);
        add(1, 4'h9, 1, 4'h5, 1, 1, 16'd3);
        add(0, 4'h0, 0, 4'h5, 0, 1, 16'd3);
        add(0, 4'h0, 1, 4'h9, 1, 1, 16'd4);
        add(0, 4'h0, 0, 4'h9, 0, 0, 16'd4);
        n_pre   = 0;
        pre_cur = 4'h9;
        pre_cnt = 16'd4;
`endif

        // Reset with coincident request and period_end; reset must dominate.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_cur",  {12'h0, o_cur_div},   16'h000F);
        check("rst_upd",  {15'h0, o_upd_valid}, 16'h0000);
        check("rst_busy", {15'h0, o_busy},      16'h0000);
        check("rst_cnt",  o_upd_count,          16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].rv, vecs[i].d, vecs[i].pe);
            check($sformatf("v%0d_cur", i),  {12'h0, o_cur_div},   {12'h0, vecs[i].cur});
            check($sformatf("v%0d_upd", i),  {15'h0, o_upd_valid}, {15'h0, vecs[i].upd});
            check($sformatf("v%0d_busy", i), {15'h0, o_busy},      {15'h0, vecs[i].busy});
            check($sformatf("v%0d_cnt", i),  o_upd_count,          vecs[i].cnt);
        end

        // Reset in the middle of a slew toward MIN_DIV.
        step(1'b0, 1'b1, 4'h2, 1'b0);
        guard = 0;
        while (!o_busy && guard < 10) begin
            step(1'b0, 1'b0, 4'h0, 1'b0);
            guard++;
        end
        check("slew_busy_wait", {15'h0, o_busy}, 16'h0001);
        for (int k = 0; k < n_pre; k++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1);
        end
        check("pre_rst_cur", {12'h0, o_cur_div}, {12'h0, pre_cur});
        check("pre_rst_cnt", o_upd_count,        pre_cnt);
        step(1'b1, 1'b1, 4'h4, 1'b1);
        check("abort_cur",  {12'h0, o_cur_div},   16'h000F);
        check("abort_upd",  {15'h0, o_upd_valid}, 16'h0000);
        check("abort_busy", {15'h0, o_busy},      16'h0000);
        check("abort_cnt",  o_upd_count,          16'h0000);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_cur",  {12'h0, o_cur_div},   16'h000F);
        check("post_upd",  {15'h0, o_upd_valid}, 16'h0000);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        check("post_busy", {15'h0, o_busy},      16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_slew_sequencer.md
DIV_SLEW_SEQUENCER -- requirements
Module: div_slew_sequencer

Interface
REQ-001 Parameter DIV_W, default 4: width of every divisor value.
REQ-002 Parameter MIN_DIV, default 2: smallest divisor the block accepts.
REQ-003 Parameter MAX_STEP, default 1: largest change to cur_div per update; SHALL be 1..2^DIV_W-1.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req_valid  input  1  one-cycle qualifier for req_div.
REQ-007 req_div  input  DIV_W  requested divisor from the execution controller.
REQ-008 period_end  input  1  one-cycle pulse when the generated slow-clock period completes; the only point where cur_div may change.
REQ-009 cur_div  output  DIV_W  divisor presented to the clock generator; registered.
REQ-010 upd_valid  output  1  one-cycle pulse, asserted in the cycle cur_div first shows a new value.
REQ-011 busy  output  1  high while cur_div differs from the target.
REQ-012 upd_count  output  16  number of cur_div updates since reset.

Function
REQ-013 The block SHALL hold a target register tgt; when req_valid=1, tgt SHALL load req_div on the next edge, or all-ones if req_div < MIN_DIV.
REQ-014 Back-to-back requests: the last req_valid before an update wins; requests are never queued.
REQ-015 FSM states: IDLE (cur_div==tgt), WAIT (cur_div!=tgt, waiting for period_end).
REQ-016 IDLE->WAIT on the edge after tgt becomes unequal to cur_div; WAIT->IDLE when tgt==cur_div, including a new request equal to cur_div, with no update issued.
REQ-017 In WAIT with period_end=1, cur_div SHALL move toward tgt by min(MAX_STEP, |tgt-cur_div|) on that edge.
REQ-018 Step arithmetic SHALL use DIV_W+1 bits; cur_div SHALL never overshoot tgt and SHALL never wrap.
REQ-019 period_end in IDLE SHALL be ignored.
REQ-020 When req_valid and period_end coincide in WAIT, the step SHALL use the old tgt and the new tgt SHALL be captured; the next period_end uses the new tgt.
REQ-021 upd_valid SHALL be 1 for exactly one cycle per change of cur_div, aligned with the new value; latency from period_end to upd_valid is 1 cycle.
REQ-022 upd_count SHALL increment by 1 per upd_valid and saturate at 16'hFFFF.
REQ-023 busy SHALL be a registered decode of state==WAIT.

Reset
REQ-024 On reset=1 at a clk edge: cur_div=all-ones, tgt=all-ones, state=IDLE, upd_valid=0, busy=0, upd_count=0.
REQ-025 Reset SHALL take priority over req_valid and period_end in the same cycle and SHALL abort any slew in progress.

Configuration
REQ-026 Macro DIV_SLEW_SEQUENCER_SLEW_EN, when defined, SHALL enable MAX_STEP slew limiting as in REQ-017.
REQ-027 When the macro is undefined, MAX_STEP SHALL be ignored: cur_div SHALL jump directly to tgt on the first period_end in WAIT, with one upd_valid pulse; all other behaviour is unchanged.

Verification
REQ-028 Reset, then idle 10 cycles with period_end pulsing -> cur_div=4'hF, upd_valid never set, busy=0, upd_count=0.
REQ-029 With slew enabled and MAX_STEP=1, request 4'hC, then 3 period_end pulses -> cur_div reads F,E,D,C; 3 upd_valid pulses; busy drops after C; upd_count=3.
REQ-030 Request 4'h1 (below MIN_DIV=2) while cur_div=4'hC -> tgt=4'hF; the slew goes up to F.
REQ-031 Mid-slew at cur_div=4'hD toward 4'h8, request 4'hD coincident with period_end -> cur_div=4'hC on that edge, then slews back to D; 1 further upd_valid pulse.
REQ-032 Macro undefined, request 4'h3 from 4'hF -> cur_div=4'h3 one cycle after the first period_end; a single upd_valid pulse.
REQ-033 Assert reset mid-slew at cur_div=4'hA -> next cycle cur_div=4'hF, busy=0, upd_count=0, no upd_valid pulse.
